// File: rtl/drop_sequencer.sv
// Connect-4 drop sequencer: owns the board (heights, owners, move count) and drives
// renderer draw/erase transactions for one piece drop. Falling animation: DROP_ANIMATE_EN.
module drop_sequencer #(
    parameter int COLS = 7,
    parameter int ROWS = 6,
    parameter int CELL = 16,
    parameter int X0   = 8,
    parameter int Y0   = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req,
    input  logic [2:0] column,
    input  logic [1:0] player,
    output logic       col_ok,
    output logic       busy,
    output logic       done,
    output logic       reject,
    output logic       draw,
    output logic [7:0] draw_x,
    output logic [6:0] draw_y,
    output logic [2:0] colour,
    input  logic       draw_done,
    input  logic [2:0] rd_col,
    input  logic [2:0] rd_row,
    output logic [1:0] rd_owner,
    output logic       board_full,
    output logic [5:0] moves
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAW   = 3'd1,
        ST_GAP_D  = 3'd2,
        ST_ERASE  = 3'd3,
        ST_GAP_E  = 3'd4,
        ST_COMMIT = 3'd5
    } state_t;

    localparam logic [3:0] COLS_W    = 4'(COLS);
    localparam logic [2:0] ROWS_W    = 3'(ROWS);
    localparam logic [5:0] MAX_MOVES = 6'(COLS * ROWS);
`ifdef DROP_ANIMATE_EN
    localparam logic [2:0] TOP_ROW   = 3'(ROWS - 1);
`endif

    state_t      state_r, state_s;
    logic [2:0]  col_r, col_s;
    logic [1:0]  player_r, player_s;
    logic [2:0]  target_r, target_s;
    logic [2:0]  row_r, row_s;
    logic [2:0]  height_r [COLS];
    logic [1:0]  owner_r  [COLS][ROWS];
    logic [5:0]  moves_r;
    logic        busy_r, done_r, reject_r, draw_r;
    logic        busy_s, done_s, reject_s, draw_s;
    logic [7:0]  draw_x_r, draw_x_s;
    logic [6:0]  draw_y_r, draw_y_s;
    logic [2:0]  colour_r, colour_s;
    logic        col_ok_s, legal_s, full_s;
    logic [1:0]  rd_owner_s;

    function automatic logic [7:0] x_of(input logic [2:0] c);
        x_of = 8'(X0 + int'(c) * CELL);
    endfunction

    function automatic logic [6:0] y_of(input logic [2:0] r);
        y_of = 7'(Y0 + (ROWS - 1 - int'(r)) * CELL);
    endfunction

    // Column validity and request legality seen by the game FSM
    always_comb begin
        col_ok_s = 1'b0;
        if ({1'b0, column} < COLS_W) begin
            col_ok_s = (height_r[column] < ROWS_W);
        end else begin
            col_ok_s = 1'b0;
        end
        legal_s = col_ok_s && ((player == 2'd1) || (player == 2'd2));
    end

    // Board read port and full-board detection
    always_comb begin
        rd_owner_s = 2'd0;
        if (({1'b0, rd_col} < COLS_W) && (rd_row < ROWS_W)) begin
            rd_owner_s = owner_r[rd_col][rd_row];
        end else begin
            rd_owner_s = 2'd0;
        end
        full_s = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (height_r[c] != ROWS_W) begin
                full_s = 1'b0;
            end else begin
                full_s = full_s;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state and drop context (column, player, target, current row)
    always_comb begin
        state_s  = state_r;
        col_s    = col_r;
        player_s = player_r;
        target_s = target_r;
        row_s    = row_r;
        case (state_r)
            ST_IDLE: begin
                if (req && legal_s) begin
                    state_s  = ST_DRAW;
                    col_s    = column;
                    player_s = player;
                    target_s = height_r[column];
`ifdef DROP_ANIMATE_EN
                    row_s    = TOP_ROW;
`else
                    row_s    = height_r[column];
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRAW: begin
                if (draw_done) state_s = ST_GAP_D;
                else           state_s = ST_DRAW;
            end
            ST_GAP_D: begin
                if (row_r == target_r) state_s = ST_COMMIT;
                else                   state_s = ST_ERASE;
            end
            ST_ERASE: begin
                if (draw_done) state_s = ST_GAP_E;
                else           state_s = ST_ERASE;
            end
            ST_GAP_E: begin
                state_s = ST_DRAW;
                row_s   = row_r - 3'd1;
            end
            ST_COMMIT: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Output decode: registered outputs are computed from the upcoming state
    always_comb begin
        busy_s   = (state_s != ST_IDLE);
        done_s   = (state_s == ST_COMMIT);
        reject_s = (state_r == ST_IDLE) && req && !legal_s;
        draw_s   = (state_s == ST_DRAW) || (state_s == ST_ERASE);
        draw_x_s = draw_x_r;
        draw_y_s = draw_y_r;
        colour_s = colour_r;
        case (state_s)
            ST_DRAW: begin
                draw_x_s = x_of(col_s);
                draw_y_s = y_of(row_s);
                colour_s = (player_s == 2'd2) ? 3'b110 : 3'b100;
            end
            ST_ERASE: begin
                draw_x_s = x_of(col_s);
                draw_y_s = y_of(row_s);
                colour_s = 3'b000;
            end
            default: begin
                draw_x_s = draw_x_r;
                draw_y_s = draw_y_r;
                colour_s = colour_r;
            end
        endcase
    end

    // Drop context, output registers and board commit
    always_ff @(posedge clk) begin
        if (!resetn) begin
            col_r    <= 3'd0;
            player_r <= 2'd0;
            target_r <= 3'd0;
            row_r    <= 3'd0;
            moves_r  <= 6'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            reject_r <= 1'b0;
            draw_r   <= 1'b0;
            draw_x_r <= 8'd0;
            draw_y_r <= 7'd0;
            colour_r <= 3'd0;
            for (int c = 0; c < COLS; c++) begin
                height_r[c] <= 3'd0;
                for (int r = 0; r < ROWS; r++) begin
                    owner_r[c][r] <= 2'd0;
                end
            end
        end else begin
            col_r    <= col_s;
            player_r <= player_s;
            target_r <= target_s;
            row_r    <= row_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            reject_r <= reject_s;
            draw_r   <= draw_s;
            draw_x_r <= draw_x_s;
            draw_y_r <= draw_y_s;
            colour_r <= colour_s;
            if ((state_r == ST_COMMIT) && (height_r[col_r] < ROWS_W)) begin
                owner_r[col_r][target_r] <= player_r;
                height_r[col_r]          <= height_r[col_r] + 3'd1;
                if (moves_r < MAX_MOVES) moves_r <= moves_r + 6'd1;
                else                     moves_r <= moves_r;
            end else begin
                moves_r <= moves_r;
            end
        end
    end

    assign col_ok     = col_ok_s;
    assign rd_owner   = rd_owner_s;
    assign board_full = full_s;
    assign busy       = busy_r;
    assign done       = done_r;
    assign reject     = reject_r;
    assign draw       = draw_r;
    assign draw_x     = draw_x_r;
    assign draw_y     = draw_y_r;
    assign colour     = colour_r;
    assign moves      = moves_r;

endmodule

// File: tb/tb_drop_sequencer.sv
// Directed bench for drop_sequencer with hand-computed expectations; a small
// renderer model answers each draw/erase with a one-cycle draw_done.
module tb_drop_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       req = 1'b0;
    logic [2:0] column = 3'd0;
    logic [1:0] player = 2'd0;
    logic       col_ok, busy, done, reject, draw;
    logic [7:0] draw_x;
    logic [6:0] draw_y;
    logic [2:0] colour;
    logic       draw_done = 1'b0;
    logic [2:0] rd_col = 3'd0;
    logic [2:0] rd_row = 3'd0;
    logic [1:0] rd_owner;
    logic       board_full;
    logic [5:0] moves;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int n_draws, n_erases, n_done;
    logic [6:0] ys [8];
    logic [2:0] last_colour;

    drop_sequencer dut (
        .clk(clk), .resetn(resetn), .req(req), .column(column), .player(player),
        .col_ok(col_ok), .busy(busy), .done(done), .reject(reject), .draw(draw),
        .draw_x(draw_x), .draw_y(draw_y), .colour(colour), .draw_done(draw_done),
        .rd_col(rd_col), .rd_row(rd_row), .rd_owner(rd_owner),
        .board_full(board_full), .moves(moves)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        check_cnt++;
        if (obs === exp_v) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; req = 1'b0; draw_done = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Issue one request and act as the renderer until done; returns one cycle after done
    task automatic do_drop(input logic [2:0] c, input logic [1:0] p);
        int cyc;
        n_draws = 0; n_erases = 0; n_done = 0; cyc = 0;
        @(negedge clk);
        column = c; player = p; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        while (!done && cyc < 200) begin
            if (draw && !draw_done) begin
                if (colour != 3'd0) begin
                    if (n_draws < 8) ys[n_draws] = draw_y;
                    last_colour = colour;
                    n_draws++;
                end else begin
                    n_erases++;
                end
                draw_done = 1'b1;
            end else begin
                draw_done = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        draw_done = 1'b0;
        if (cyc >= 200) begin
            check_value("drop_timeout", 32'd0, 32'd1);
        end else begin
            n_done = 1;
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        column = 3'd3; player = 2'd1;
        check_value("rst_draw", 32'(draw), 32'd0);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_done", 32'(done), 32'd0);
        check_value("rst_reject", 32'(reject), 32'd0);
        check_value("rst_moves", 32'(moves), 32'd0);
        check_value("rst_draw_x", 32'(draw_x), 32'd0);
        check_value("rst_draw_y", 32'(draw_y), 32'd0);
        check_value("rst_colour", 32'(colour), 32'd0);
        check_value("rst_full", 32'(board_full), 32'd0);
        check_value("rst_col_ok", 32'(col_ok), 32'd1);

        // Single drop into column 3 with exact cycle timing
`ifndef DROP_ANIMATE_EN
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check_value("sd_draw", 32'(draw), 32'd1);
        check_value("sd_busy", 32'(busy), 32'd1);
        check_value("sd_x", 32'(draw_x), 32'd56);
        check_value("sd_y", 32'(draw_y), 32'd88);
        check_value("sd_colour", 32'(colour), 32'd4);
        @(negedge clk);
        @(negedge clk);
        draw_done = 1'b1;
        @(negedge clk);
        draw_done = 1'b0;
        check_value("sd_gap_draw", 32'(draw), 32'd0);
        check_value("sd_gap_done", 32'(done), 32'd0);
        @(negedge clk);
        check_value("sd_done", 32'(done), 32'd1);
        @(negedge clk);
        check_value("sd_done_low", 32'(done), 32'd0);
        check_value("sd_busy_low", 32'(busy), 32'd0);
        check_value("sd_x_hold", 32'(draw_x), 32'd56);
`else
        do_drop(3'd3, 2'd1);
        check_value("sd_draws", 32'(n_draws), 32'd6);
`endif
        rd_col = 3'd3; rd_row = 3'd0;
        #1 check_value("sd_owner", 32'(rd_owner), 32'd1);
        check_value("sd_moves", 32'(moves), 32'd1);

        // Player 2 colour, column 5
        do_drop(3'd5, 2'd2);
        check_value("p2_colour", 32'(last_colour), 32'd6);
        rd_col = 3'd5; rd_row = 3'd0;
        #1 check_value("p2_owner", 32'(rd_owner), 32'd2);

        // Drop into empty column 2: one draw, or the full fall with animation
        do_drop(3'd2, 2'd1);
        check_value("an_done", 32'(n_done), 32'd1);
`ifdef DROP_ANIMATE_EN
        check_value("an_draws", 32'(n_draws), 32'd6);
        check_value("an_erases", 32'(n_erases), 32'd5);
        for (int i = 0; i < 6; i++) check_value("an_y", 32'(ys[i]), 32'(8 + 16 * i));
`else
        check_value("an_draws", 32'(n_draws), 32'd1);
        check_value("an_erases", 32'(n_erases), 32'd0);
        check_value("an_y", 32'(ys[0]), 32'd88);
`endif
        check_value("an_moves", 32'(moves), 32'd3);

        // Column full: seventh request into column 0 is rejected
        do_reset();
        for (int i = 0; i < 6; i++) do_drop(3'd0, 2'd1);
        column = 3'd0; player = 2'd1;
        #1 check_value("cf_col_ok", 32'(col_ok), 32'd0);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check_value("cf_reject", 32'(reject), 32'd1);
        check_value("cf_draw", 32'(draw), 32'd0);
        check_value("cf_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_value("cf_reject_low", 32'(reject), 32'd0);
        check_value("cf_moves", 32'(moves), 32'd6);
        rd_col = 3'd0; rd_row = 3'd5;
        #1 check_value("cf_top_owner", 32'(rd_owner), 32'd1);

        // Illegal column, then illegal player
        column = 3'd7; player = 2'd1;
        #1 check_value("il_col7_ok", 32'(col_ok), 32'd0);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check_value("il_col7_reject", 32'(reject), 32'd1);
        check_value("il_col7_draw", 32'(draw), 32'd0);
        column = 3'd2; player = 2'd0;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check_value("il_p0_reject", 32'(reject), 32'd1);
        check_value("il_p0_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_value("il_moves", 32'(moves), 32'd6);
        rd_col = 3'd2; rd_row = 3'd0;
        #1 check_value("il_owner", 32'(rd_owner), 32'd0);
        check_value("il_col2_ok", 32'(col_ok), 32'd1);

        // Reset while in DRAW abandons the drop
        do_reset();
        @(negedge clk);
        column = 3'd4; player = 2'd2; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check_value("rm_draw_hi", 32'(draw), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        check_value("rm_draw_lo", 32'(draw), 32'd0);
        check_value("rm_busy_lo", 32'(busy), 32'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check_value("rm_done", 32'(done), 32'd0);
        check_value("rm_moves", 32'(moves), 32'd0);
        rd_col = 3'd4; rd_row = 3'd0;
        #1 check_value("rm_owner", 32'(rd_owner), 32'd0);

        // Fill the whole board with alternating players
        do_reset();
        for (int i = 0; i < 42; i++) do_drop(3'(i / 6), 2'(1 + (i % 2)));
        check_value("bf_full", 32'(board_full), 32'd1);
        check_value("bf_moves", 32'(moves), 32'd42);
        for (int c = 0; c < 7; c++) begin
            column = 3'(c);
            #1 check_value("bf_col_ok", 32'(col_ok), 32'd0);
        end
        rd_col = 3'd6; rd_row = 3'd5;
        #1 check_value("bf_owner_65", 32'(rd_owner), 32'd2);
        rd_col = 3'd0; rd_row = 3'd0;
        #1 check_value("bf_owner_00", 32'(rd_owner), 32'd1);
        rd_col = 3'd3; rd_row = 3'd6;
        #1 check_value("bf_owner_oob", 32'(rd_owner), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
